// File: rtl/udp_rx_pkg.sv
// udp_rx_pkg: header offsets, protocol constants and parser state for the UDP receive path
package udp_rx_pkg;
    localparam int HDR_LEN = 42;
    localparam logic [5:0] OFF_SRC_MAC  = 6'd6;
    localparam logic [5:0] OFF_ETH_TYPE = 6'd12;
    localparam logic [5:0] OFF_VER_IHL  = 6'd14;
    localparam logic [5:0] OFF_PROTO    = 6'd23;
    localparam logic [5:0] OFF_SRC_IP   = 6'd26;
    localparam logic [5:0] OFF_DST_IP   = 6'd30;
    localparam logic [5:0] OFF_SRC_PORT = 6'd34;
    localparam logic [5:0] OFF_DST_PORT = 6'd36;
    localparam logic [5:0] OFF_UDP_LEN  = 6'd38;
    localparam logic [5:0] OFF_LAST     = 6'(HDR_LEN - 1);
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0] IP_VER_IHL = 8'h45;
    localparam logic [7:0] IP_PROTO_UDP = 8'h11;
    localparam logic [47:0] BCAST_MAC = 48'hffff_ffff_ffff;
    typedef enum logic [1:0] {HDR, PAYLOAD, DRAIN} state_t;
    function automatic logic [7:0] sel_byte(input logic [47:0] v, input logic [5:0] i);
        logic [47:0] t;
        t = v >> {i, 3'b000};
        return t[7:0];
    endfunction
endpackage

// File: rtl/udp_rx_out_reg.sv
// udp_rx_out_reg: single-entry data/last/user register slice with valid/ready handshake
module udp_rx_out_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    input  logic       in_user,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    output logic       out_user,
    input  logic       out_ready
);
    assign in_ready = !out_valid || out_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            out_user <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            out_last <= in_valid && in_last;
            out_user <= in_valid && in_user;
            if (in_valid) out_data <= in_data;
        end
    end
endmodule

// File: rtl/udp_rx_parser.sv
// udp_rx_parser: checks Ethernet/IPv4/UDP headers against local addresses and streams out the UDP payload
module udp_rx_parser import udp_rx_pkg::*; #(
    parameter int ACCEPT_BCAST = 1,
    parameter int CHECK_IP_DST = 1,
    parameter int CHECK_UDP_PORT = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic [47:0]          local_mac,
    input  logic [31:0]          local_ip,
    input  logic [15:0]          local_port,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic                 hdr_valid,
    output logic [47:0]          rx_src_mac,
    output logic [31:0]          rx_src_ip,
    output logic [15:0]          rx_src_port,
    output logic [15:0]          rx_len,
    output logic                 pkt_ok,
    output logic                 pkt_drop,
    output logic [CNT_WIDTH-1:0] drop_cnt
);
    state_t state;
    logic [5:0] byte_cnt, sel;
    logic [15:0] rem, len_sh, port_sh;
    logic [47:0] mac_sh;
    logic [31:0] ip_sh;
    logic fail_q, ucast_q, bcast_q, fail_n, ucast_n, bcast_n;
    logic first, in_mac, in_ip, in_port, chk, hdr_bad, beat, slice_ready, last_cnt;
    logic [7:0] want;
    always_comb begin
        first = byte_cnt == 6'd0;
        in_mac = byte_cnt < OFF_SRC_MAC;
        in_ip = byte_cnt >= OFF_DST_IP && byte_cnt < OFF_SRC_PORT;
        in_port = byte_cnt >= OFF_DST_PORT && byte_cnt < OFF_UDP_LEN;
        sel = in_mac ? 6'd5 - byte_cnt : in_ip ? OFF_DST_IP + 6'd3 - byte_cnt : OFF_DST_PORT + 6'd1 - byte_cnt;
        want = in_mac ? sel_byte(local_mac, sel) :
               in_ip ? sel_byte({16'h0, local_ip}, sel) :
               in_port ? sel_byte({32'h0, local_port}, sel) :
               byte_cnt == OFF_ETH_TYPE ? ETH_TYPE_IPV4[15:8] :
               byte_cnt == OFF_ETH_TYPE + 6'd1 ? ETH_TYPE_IPV4[7:0] :
               byte_cnt == OFF_VER_IHL ? IP_VER_IHL : IP_PROTO_UDP;
        chk = byte_cnt inside {OFF_ETH_TYPE, OFF_ETH_TYPE + 6'd1, OFF_VER_IHL, OFF_PROTO} ||
              (CHECK_IP_DST != 0 && in_ip) || (CHECK_UDP_PORT != 0 && in_port);
        // flags restart on byte 0 so no explicit clear is needed between frames
        fail_n = (!first && fail_q) || (chk && s_axis_tdata != want);
        ucast_n = (first || ucast_q) && (!in_mac || s_axis_tdata == want);
        bcast_n = (first || bcast_q) && (!in_mac || s_axis_tdata == BCAST_MAC[7:0]);
        hdr_bad = fail_q || !(ucast_q || (ACCEPT_BCAST != 0 && bcast_q)) || len_sh < 16'd8;
        beat = s_axis_tvalid && s_axis_tready;
        last_cnt = rem == 16'd1;
        s_axis_tready = !rst && (state != PAYLOAD || slice_ready);
    end
    udp_rx_out_reg u_out (
        .clk(sys_clk),
        .rst(rst),
        .in_data(s_axis_tdata),
        .in_valid(beat && state == PAYLOAD),
        .in_last(last_cnt || s_axis_tlast),
        .in_user(s_axis_tlast && (!last_cnt || s_axis_tuser)),
        .in_ready(slice_ready),
        .out_data(m_axis_tdata),
        .out_valid(m_axis_tvalid),
        .out_last(m_axis_tlast),
        .out_user(m_axis_tuser),
        .out_ready(m_axis_tready)
    );
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= HDR;
            byte_cnt <= '0;
            rem <= '0;
            fail_q <= 1'b0;
            ucast_q <= 1'b0;
            bcast_q <= 1'b0;
            mac_sh <= '0;
            ip_sh <= '0;
            port_sh <= '0;
            len_sh <= '0;
            hdr_valid <= 1'b0;
            pkt_ok <= 1'b0;
            pkt_drop <= 1'b0;
            rx_src_mac <= '0;
            rx_src_ip <= '0;
            rx_src_port <= '0;
            rx_len <= '0;
            drop_cnt <= '0;
        end else begin
            hdr_valid <= 1'b0;
            pkt_ok <= 1'b0;
            pkt_drop <= 1'b0;
            drop_cnt <= drop_cnt + {{(CNT_WIDTH-1){1'b0}}, pkt_drop && !(&drop_cnt)};
            if (beat) begin
                case (state)
                    HDR: begin
                        fail_q <= fail_n;
                        ucast_q <= ucast_n;
                        bcast_q <= bcast_n;
                        byte_cnt <= byte_cnt + 6'd1;
                        if (byte_cnt >= OFF_SRC_MAC && byte_cnt < OFF_ETH_TYPE) mac_sh <= {mac_sh[39:0], s_axis_tdata};
                        if (byte_cnt >= OFF_SRC_IP && byte_cnt < OFF_DST_IP) ip_sh <= {ip_sh[23:0], s_axis_tdata};
                        if (byte_cnt >= OFF_SRC_PORT && byte_cnt < OFF_DST_PORT) port_sh <= {port_sh[7:0], s_axis_tdata};
                        if (byte_cnt >= OFF_UDP_LEN && byte_cnt < OFF_UDP_LEN + 6'd2) len_sh <= {len_sh[7:0], s_axis_tdata};
                        if (byte_cnt == OFF_LAST) begin
                            byte_cnt <= '0;
                            if (hdr_bad) begin
                                pkt_drop <= 1'b1;
                                state <= s_axis_tlast ? HDR : DRAIN;
                            end else begin
                                hdr_valid <= 1'b1;
                                rx_src_mac <= mac_sh;
                                rx_src_ip <= ip_sh;
                                rx_src_port <= port_sh;
                                rx_len <= len_sh - 16'd8;
                                rem <= len_sh - 16'd8;
                                if (len_sh == 16'd8) begin
                                    pkt_ok <= 1'b1;
                                    state <= s_axis_tlast ? HDR : DRAIN;
                                end else if (s_axis_tlast) begin
                                    pkt_drop <= 1'b1;
                                end else begin
                                    state <= PAYLOAD;
                                end
                            end
                        end else if (s_axis_tlast) begin
                            byte_cnt <= '0;
                            pkt_drop <= 1'b1;
                        end
                    end
                    PAYLOAD: begin
                        rem <= rem - 16'd1;
                        if (last_cnt) begin
                            pkt_ok <= !(s_axis_tlast && s_axis_tuser);
                            pkt_drop <= s_axis_tlast && s_axis_tuser;
                            state <= s_axis_tlast ? HDR : DRAIN;
                        end else if (s_axis_tlast) begin
                            pkt_drop <= 1'b1;
                            state <= HDR;
                        end
                    end
                    DRAIN: if (s_axis_tlast) state <= HDR;
                    default: state <= HDR;
                endcase
            end
        end
    end
endmodule
